hd_cfg_arbiter: RTL and testbench

Shares the single configuration port of the HD accelerator between NUM_REQ configuration masters, e.g. the host bus bridge and an autonomous AM/IM preload engine. The block does round-robin arbitration on the req/gnt handshake. It keeps an in-order FIFO of requester IDs so that every downstream rvalid/rdata is returned to the requester that issued it, and it throttles new grants when the number of outstanding transactions reaches its limit. It sits between the masters and the accelerator's cfg_* port and is clocked by the accelerator clock.

---
 rtl/pkg_common.sv | 5 +
 rtl/pkg_hd_cfg_arb.sv | 6 +
 rtl/pkg_memory_mapping.sv | 5 +
 rtl/hd_cfg_id_fifo.sv | 49 ++++
 rtl/hd_cfg_arbiter.sv | 98 +++++++++
 tb/tb_hd_cfg_arbiter.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/pkg_common.sv
// Project-wide basic types shared by all accelerator blocks.
package pkg_common;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/pkg_hd_cfg_arb.sv
// Shared defaults and types for the configuration-port arbiter.
package pkg_hd_cfg_arb;
  localparam int NUM_REQ_DEF         = 2;
  localparam int MAX_OUTSTANDING_DEF = 2;
  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;
endpackage

// File: rtl/pkg_memory_mapping.sv
// Address types of the accelerator configuration space.
package pkg_memory_mapping;
  localparam int CFG_ADDR_W = 16;
  typedef logic [CFG_ADDR_W-1:0] cfg_addr_t;
endpackage

// File: rtl/hd_cfg_id_fifo.sv
// In-order FIFO of requester IDs for granted but not yet answered transactions.
module hd_cfg_id_fifo #(
  parameter  int DEPTH = 2,
  parameter  int ID_W  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [ID_W-1:0]  push_id_i,
  input  logic             pop_i,
  output logic [ID_W-1:0]  head_id_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (count_o == CNT_W'(DEPTH));
  assign empty_o   = (count_o == '0);
  assign do_pop    = pop_i && !empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push   = push_i && (!full_o || pop_i);
  assign head_id_o = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count_o <= count_o + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id_i;
  end
endmodule

// File: rtl/hd_cfg_arbiter.sv
// Round-robin sharing of the accelerator cfg port between NUM_REQ masters,
// with in-order response routing and an outstanding-transaction limit.
module hd_cfg_arbiter
  import pkg_common::*;
  import pkg_memory_mapping::*;
  import pkg_hd_cfg_arb::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic      [NUM_REQ-1:0]    req_i,
  output logic      [NUM_REQ-1:0]    gnt_o,
  input  logic      [NUM_REQ-1:0]    wen_i,
  input  cfg_addr_t [NUM_REQ-1:0]    addr_i,
  input  word_t     [NUM_REQ-1:0]    wdata_i,
  output word_t                      rdata_o,
  output logic      [NUM_REQ-1:0]    rvalid_o,
  output logic                       cfg_req_o,
  output logic                       cfg_wen_o,
  output cfg_addr_t                  cfg_addr_o,
  output word_t                      cfg_wdata_o,
  input  logic                       cfg_gnt_i,
  input  logic                       cfg_rvalid_i,
  input  word_t                      cfg_rdata_i,
  output logic                       err_o
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  typedef logic [ID_W-1:0] id_t;

  id_t              ptr, win_id, head_id;
  logic             win_vld, hs, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] cnt;

  // Find-first eligible requester starting at ptr; the registered fill level
  // gates eligibility, so a pop this cycle frees its slot only next cycle.
  always_comb begin
    int k;
    k       = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_vld && !fifo_full && req_i[k]) begin
        win_vld = 1'b1;
        win_id  = id_t'(k);
      end
    end
  end

  assign cfg_req_o   = win_vld;
  assign cfg_wen_o   = win_vld ? wen_i[win_id]   : 1'b1;
  assign cfg_addr_o  = win_vld ? addr_i[win_id]  : '0;
  assign cfg_wdata_o = win_vld ? wdata_i[win_id] : '0;
  assign hs          = win_vld && cfg_gnt_i;
  assign pop         = cfg_rvalid_i && !fifo_empty;
  assign rdata_o     = pop ? cfg_rdata_i : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (win_vld) gnt_o[win_id]   = cfg_gnt_i;
    if (pop)     rvalid_o[head_id] = 1'b1;
  end

  hd_cfg_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (hs),
    .push_id_i (win_id),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr   <= '0;
      err_o <= 1'b0;
    end else begin
      if (hs) ptr <= (win_id == id_t'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      if (cfg_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  // The full flag and the fill level describe the same state.
  a_full_cnt : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_full == (cnt == CNT_W'(MAX_OUTSTANDING)));
endmodule

// File: tb/tb_hd_cfg_arbiter.sv
// Bench for hd_cfg_arbiter: directed scenarios plus randomized traffic,
// both checked against a queue-based transaction model.
module tb_hd_cfg_arbiter;
  import pkg_common::*;
  import pkg_memory_mapping::*;

  localparam int N   = 2;
  localparam int MAX = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic      [N-1:0]   req, wen;
  cfg_addr_t [N-1:0]   addr;
  word_t     [N-1:0]   wdata;
  logic                cfg_gnt, cfg_rvalid;
  word_t               cfg_rdata;
  logic      [N-1:0]   gnt_o, rvalid_o;
  word_t               rdata_o, cfg_wdata_o;
  logic                cfg_req_o, cfg_wen_o, err_o;
  cfg_addr_t           cfg_addr_o;

  always #5 clk = ~clk;

  hd_cfg_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o), .wen_i(wen),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .cfg_req_o(cfg_req_o), .cfg_wen_o(cfg_wen_o), .cfg_addr_o(cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o), .cfg_gnt_i(cfg_gnt), .cfg_rvalid_i(cfg_rvalid),
    .cfg_rdata_i(cfg_rdata), .err_o(err_o)
  );

  // Model: outstanding transactions as a queue of (requester, grant cycle).
  typedef struct { int id; int cyc; } ent_t;
  ent_t mq[$];
  int   m_ptr, now, m_win;
  bit   m_err, m_hs;
  int   n_cmp, n_mis;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    req = '0; cfg_gnt = 1'b0; cfg_rvalid = 1'b0; cfg_rdata = '0;
  endtask

  task automatic model_reset();
    mq.delete(); m_ptr = 0; m_err = 1'b0;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next one.
  task automatic cycle();
    int win;
    logic [N-1:0] e_gnt, e_rv;
    word_t e_rd;
    #1;
    win = -1;
    if (mq.size() < MAX)
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (win < 0 && req[k]) win = k;
      end
    e_gnt = '0; e_rv = '0; e_rd = '0;
    if (win >= 0 && cfg_gnt) e_gnt[win] = 1'b1;
    chk("cfg_req", cfg_req_o, win >= 0);
    chk("gnt", gnt_o, e_gnt);
    if (win >= 0) begin
      chk("cfg_addr", cfg_addr_o, addr[win]);
      chk("cfg_wdata", cfg_wdata_o, wdata[win]);
      chk("cfg_wen", cfg_wen_o, wen[win]);
    end
    if (cfg_rvalid && mq.size() > 0) begin
      e_rv[mq[0].id] = 1'b1;
      e_rd = cfg_rdata;
    end
    chk("rvalid", rvalid_o, e_rv);
    chk("rdata", rdata_o, e_rd);
    chk("err", err_o, m_err);
    if (cfg_rvalid) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_err = 1'b1;
    end
    m_hs  = (win >= 0) && cfg_gnt;
    m_win = win;
    if (m_hs) begin
      mq.push_back('{id: win, cyc: now});
      m_ptr = (win + 1) % N;
    end
    now++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_cfg_req", cfg_req_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic  [N-1:0] pend;
  int            ngr;

  initial begin
    n_cmp = 0; n_mis = 0; now = 0;
    wen = '1; addr = '0; wdata = '0;
    idle();
    model_reset();
    do_reset();

    // Single read
    req = 2'b01; wen = 2'b11; addr[0] = 16'h0010; cfg_gnt = 1'b1;
    #1 chk("sr_gnt0", gnt_o, 2'b01);
    chk("sr_addr", cfg_addr_o, 16'h0010);
    cycle();
    idle(); cycle();
    cfg_rvalid = 1'b1; cfg_rdata = 32'hCAFE;
    #1 chk("sr_rv", rvalid_o, 2'b01);
    chk("sr_rd", rdata_o, 32'hCAFE);
    cycle();
    idle();
    #1 chk("sr_err", err_o, 0);
    cycle();

    // Round-robin with both requesters always asking
    do_reset();
    addr[0] = 16'h0100; addr[1] = 16'h0200; wdata[0] = 32'h11; wdata[1] = 32'h22;
    for (int c = 0; c < 8; c++) begin
      req = 2'b11; cfg_gnt = 1'b1; cfg_rvalid = (c > 0); cfg_rdata = 32'(100 + c);
      #1 chk("rr_gnt", gnt_o, (c % 2) ? 2'b10 : 2'b01);
      if (c > 0) chk("rr_rv", rvalid_o, ((c - 1) % 2) ? 2'b10 : 2'b01);
      cycle();
    end
    idle(); cfg_rvalid = 1'b1; cfg_rdata = 32'h5A5A;
    #1 chk("rr_last_rv", rvalid_o, 2'b10);
    cycle();

    // Outstanding limit with slow responses
    do_reset();
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      req = (c <= 6) ? 2'b11 : 2'b00; cfg_gnt = 1'b1;
      cfg_rvalid = (c == 5 || c == 6 || c == 11); cfg_rdata = 32'(c);
      #1;
      if (c < 2 || c == 6) chk("ol_req_on", cfg_req_o, 1);
      else if (c < 6) chk("ol_req_off", cfg_req_o, 0);
      if (c < 6 && cfg_req_o && cfg_gnt) ngr++;
      cycle();
    end
    chk("ol_ngrant", ngr, 2);

    // Stalled downstream with ptr at 1
    do_reset();
    addr[0] = 16'h0020; addr[1] = 16'h0021;
    req = 2'b01; cfg_gnt = 1'b1; cycle();
    for (int c = 0; c < 3; c++) begin
      req = 2'b11; cfg_gnt = 1'b0;
      #1 chk("st_addr", cfg_addr_o, 16'h0021);
      chk("st_gnt", gnt_o, 2'b00);
      cycle();
    end
    req = 2'b11; cfg_gnt = 1'b1;
    #1 chk("st_win", gnt_o, 2'b10);
    cycle();
    idle(); cfg_rvalid = 1'b1; cfg_rdata = 32'hA0;
    #1 chk("st_rv0", rvalid_o, 2'b01);
    cycle();
    cfg_rvalid = 1'b1; cfg_rdata = 32'hA1;
    #1 chk("st_rv1", rvalid_o, 2'b10);
    cycle();

    // Spurious response
    do_reset();
    cfg_rvalid = 1'b1; cfg_rdata = 32'hDEAD;
    #1 chk("sp_rv", rvalid_o, 2'b00);
    cycle();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1 chk("sp_err", err_o, 1);
      cycle();
    end

    // Reset with two transactions outstanding
    do_reset();
    req = 2'b01; cfg_gnt = 1'b1; cycle();
    req = 2'b10; cfg_gnt = 1'b1; cycle();
    do_reset();
    cfg_rvalid = 1'b1; cfg_rdata = 32'hBEEF;
    #1 chk("mr_late_rv", rvalid_o, 2'b00);
    cycle();
    idle();
    #1 chk("mr_err", err_o, 1);
    req = 2'b10; cfg_gnt = 1'b1;
    #1 chk("mr_gnt", gnt_o, 2'b10);
    cycle();
    idle(); cfg_rvalid = 1'b1; cfg_rdata = 32'h1234;
    #1 chk("mr_rv", rvalid_o, 2'b10);
    cycle();

    // Randomized traffic obeying the req/gnt and in-order response protocol
    do_reset();
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          wen[i]   = 1'($urandom_range(0, 1));
          addr[i]  = cfg_addr_t'($urandom);
          wdata[i] = word_t'($urandom);
        end
      req        = pend;
      cfg_gnt    = ($urandom_range(0, 3) != 0);
      cfg_rvalid = (mq.size() > 0) && (mq[0].cyc < now) && ($urandom_range(0, 2) != 0);
      cfg_rdata  = word_t'($urandom);
      cycle();
      if (m_hs) pend[m_win] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
